// File: rtl/rr_mux_n_if.sv
// rtl/rr_mux_n_if.sv - producer/consumer handshake bundle for the round-robin registered mux
interface rr_mux_n_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) ();
  localparam int SELW = $clog2(N);

  logic             mode;
  logic [SELW-1:0]  sel;
  logic [N-1:0]     in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_ready;

  // Driven by the producers/consumer side
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  // Seen by the mux itself
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel registered mux with direct or round-robin channel grant
module rr_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input logic        clk,
  input logic        rst_n,
  rr_mux_n_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_ch;
  logic             xfer;
  logic [N-1:0]     in_ready_c;

  // Channel visited i steps after the pointer, wrapping at N (N need not be a power of two)
  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int i);
    int s;
    s = (int'(p) + i) % N;
    return SELW'(s);
  endfunction

  // The register may take a word when empty or when its current word drains this cycle
  assign load_en = !out_valid_q || bus.out_ready;
  // in_valid of the granted channel is already known to be set, so a grant plus space is a transfer
  assign xfer    = rst_n && load_en && grant_vld;

  // Grant selection: external select in direct mode, first valid from ptr in fair mode
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (!bus.mode) begin
      if (int'(bus.sel) < N) begin
        if (bus.in_valid[bus.sel]) begin
          grant_vld = 1'b1;
          grant_ch  = bus.sel;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && bus.in_valid[rr_idx(ptr_q, i)]) begin
          grant_vld = 1'b1;
          grant_ch  = rr_idx(ptr_q, i);
        end
      end
    end
  end

  // One-hot ready for the granted channel only; held low during reset and under backpressure
  always_comb begin
    in_ready_c = '0;
    if (xfer) begin
      in_ready_c[grant_ch] = 1'b1;
    end
  end

  // Next state: load replaces the held word (even while draining), drain alone clears valid only
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant_ch)*WIDTH +: WIDTH];
      out_ch_d    = grant_ch;
      ptr_d       = (grant_ch == SELW'(N-1)) ? '0 : grant_ch + SELW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer; reset discards any held word at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It is the sequential successor to the scalar 4:1 data-flow mux. Channel choice comes from one of two sources, selected per cycle by `mode`:
- an external select (direct mode);
- a built-in round-robin arbiter (fair mode).

The selected word is captured in a single output register. The block sits between several producers and one consumer in the datapath.

## Interface
Parameters:
- WIDTH, 8, data width per channel
- N, 4, number of input channels (N ≥ 2)
- SELW, $clog2(N), select/channel-index width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- mode  input  1  0 = direct select via `sel`, 1 = round-robin
- sel  input  SELW  channel index used when mode=0
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  output  N  per-channel ready, at most one bit set
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  held word
- out_ch  output  SELW  source channel of the held word
- out_ready  input  1  consumer accepts the held word

## Operation
- State:
  - output register {out_valid, out_data, out_ch};
  - round-robin pointer `ptr` (SELW bits, range 0..N-1).
- Reset (rst_n=0): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is forced to all-zero while rst_n=0.
- load_en = !out_valid || out_ready.
  - The register can accept a new word when it is empty, or in the same cycle its word drains.
- Grant selection (combinational):
  - mode=0: grant = sel if sel < N and in_valid[sel]=1; otherwise no grant.
  - mode=1: search channels ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). The first channel with in_valid set wins. No grant if in_valid=0.
- in_ready[g] = load_en && grant exists, for the granted channel g only. All other in_ready bits are 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g] at a clk edge. On transfer:
  - out_data ← in_data[g], out_ch ← g, out_valid ← 1;
  - ptr ← (g+1) mod N, in either mode.
- Drain without a new load (out_valid && out_ready, no transfer): out_valid ← 0. out_data and out_ch keep their old values.
- Simultaneous drain and load: the new word replaces the old one and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Backpressure (out_valid=1, out_ready=0):
  - out_data and out_ch stay stable;
  - in_ready is all-zero;
  - ptr does not change.
- A change of `mode` or `sel` affects only the next grant. A held word is never altered.
- sel ≥ N (possible when N is not a power of two) is treated as no grant. It is not an error and has no side effects.
- Reset asserted mid-stream discards the held word immediately (asynchronous); nothing is replayed after release.

## Timing
- Latency: an input accepted at edge t appears on out_data/out_valid just after edge t. The consumer sees it for transfer at edge t+1 at the earliest.
- in_ready is a combinational function of:
  - in_valid, mode, sel, ptr, out_valid, out_ready, rst_n.
- in_ready does not depend on in_data.
- Producers must hold in_valid and in_data stable until the transfer occurs. A producer that drops in_valid early simply loses the grant; the block does not guard against this.
- Sustained throughput: one transfer per cycle while out_ready=1 and any eligible channel is valid.
- Round-robin fairness: a continuously valid channel is granted within N transfers.
- Reset is asynchronous on assertion. Release is sampled at the first clk edge with rst_n=1. The first grant can occur in that same cycle.

## Test plan
All scenarios use N=4, WIDTH=8, and in_data channels 0..3 = 8'hA0, 8'hA1, 8'hA2, 8'hA3.
- Reset: rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000. After release in mode=1 → the first grant is ch0.
- Direct mode:
  - stimulus: mode=0, in_valid=4'b1111, out_ready=1, sel=0,2,1,3 on consecutive cycles;
  - response: out_data=A0,A2,A1,A3 one cycle later each, out_ch=0,2,1,3, in_ready one-hot matching sel;
  - then sel=2 with in_valid=4'b1011 → in_ready=4'b0000, out_valid drops to 0 after the drain.
- Round-robin, all valid: mode=1, in_valid=4'b1111, out_ready=1 for 5 cycles → out_data=A0,A1,A2,A3,A0 back-to-back, with out_valid continuously 1.
- Round-robin, sparse: mode=1, in_valid=4'b1010 from ptr=0 → grants 1,3,1,3. out_ch alternates 1/3 and ch0/ch2 never receive in_ready.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 holding A1 → out_data=A1 stable, in_ready=4'b0000, ptr unchanged. On out_ready=1 → A1 drains and the next word loads on the same edge, with no loss or duplicate.
- Reset mid-stream: pull rst_n low asynchronously between edges while out_valid=1 and ptr=2 → out_valid=0 immediately and ptr=0. After release in mode=1 with in_valid=4'b1111 → the first output is A0.
